// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH general-purpose register bank, one write port, two read ports.
// Latency: reads are combinational (0 cycles); a write lands on the next rising clk edge (same-cycle bypass optional).
// Backpressure: none; every write is accepted, writes to addresses >= DEPTH are dropped.
// Ports: clk, rst_n (async active-low clear), clear (sync clear-all), load/waddr/in (write port),
//        raddr_a/out_a and raddr_b/out_b (independent combinational read ports).
module register_file #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  out_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  out_b
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;
  logic [ADDR_W-1:0] raddr [2];
  logic [WIDTH-1:0]  rdata [2];

  assign wr_ok = load && ({1'b0, waddr} < DEPTH_V);

  // Register 0 is never written when ZERO_REG is set; its flop stays at the
  // reset value and is masked on the read side, so it trims away in synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i) && !(ZERO_REG && i == 0)) mem[i] <= in;
      end
    end
  end

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  // Decoded read: addresses >= DEPTH match no entry and fall through to 0.
  // Bypass is gated by clear (the edge will zero the array, not write it) and
  // by rst_n so reset forces both ports to 0 irrespective of the write port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr[p] == ADDR_W'(i) && !(ZERO_REG && i == 0)) rdata[p] = mem[i];
      end
      if (BYPASS && wr_ok && !clear && (waddr == raddr[p]) &&
          !(ZERO_REG && raddr[p] == '0)) begin
        rdata[p] = in;
      end
      if (!rst_n) rdata[p] = '0;
    end
  end

  assign out_a = rdata[0];
  assign out_b = rdata[1];

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: vector table plus hand sequences over four register_file configurations.
// Inputs are driven on the falling edge and outputs sampled 1 ns later, away from the rising edge.
// Expected outputs are queued per stimulus step and popped for comparison once outputs settle.
module tb_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        load  = 1'b0;
  logic [2:0]  waddr = '0;
  logic [2:0]  raddr_a = '0;
  logic [2:0]  raddr_b = '0;
  logic [15:0] din   = '0;
  logic [31:0] din32 = '0;
  logic [15:0] a0, b0, a1, b1, a2, b2;
  logic [31:0] a3, b3;

  register_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_byp (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .waddr(waddr), .in(din),
    .raddr_a(raddr_a), .out_a(a0), .raddr_b(raddr_b), .out_b(b0));

  register_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .waddr(waddr), .in(din),
    .raddr_a(raddr_a), .out_a(a1), .raddr_b(raddr_b), .out_b(b1));

  register_file #(.WIDTH(16), .DEPTH(6), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_d6z (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .waddr(waddr), .in(din),
    .raddr_a(raddr_a), .out_a(a2), .raddr_b(raddr_b), .out_b(b2));

  register_file #(.WIDTH(32), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_w32 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .waddr(waddr), .in(din32),
    .raddr_a(raddr_a), .out_a(a3), .raddr_b(raddr_b), .out_b(b3));

  typedef struct {
    logic        rst_n, clear, load;
    logic [2:0]  wa;
    logic [15:0] din;
    logic [2:0]  ra, rb;
    logic [15:0] e0a, e0b, e1a, e1b;   // expected u_byp / u_nobyp outputs before the edge
  } vec_t;

  typedef struct {
    int          dut;
    logic [31:0] ea, eb;
    string       tag;
  } exp_t;

  localparam int NV = 25;
  vec_t  vecs [NV];
  exp_t  sb [$];
  int    n_vec = 0;
  int    n_err = 0;
  logic [31:0] model32 [8];

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic l, input logic [2:0] wa,
                       input logic [15:0] d, input logic [31:0] d32,
                       input logic [2:0] ra, input logic [2:0] rb);
    @(negedge clk);
    rst_n = r; clear = c; load = l; waddr = wa; din = d; din32 = d32;
    raddr_a = ra; raddr_b = rb;
  endtask

  task automatic push(input int dut, input logic [31:0] ea, input logic [31:0] eb, input string tag);
    exp_t e;
    e.dut = dut; e.ea = ea; e.eb = eb; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin cmp({e.tag, " out_a"}, {16'h0, a0}, e.ea); cmp({e.tag, " out_b"}, {16'h0, b0}, e.eb); end
        1: begin cmp({e.tag, " out_a"}, {16'h0, a1}, e.ea); cmp({e.tag, " out_b"}, {16'h0, b1}, e.eb); end
        2: begin cmp({e.tag, " out_a"}, {16'h0, a2}, e.ea); cmp({e.tag, " out_b"}, {16'h0, b2}, e.eb); end
        default: begin cmp({e.tag, " out_a"}, a3, e.ea); cmp({e.tag, " out_b"}, b3, e.eb); end
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             rst  clr  ld   wa    din       ra    rb    byp a     byp b     nobyp a   nobyp b
    vecs[0]  = '{1'b0,1'b0,1'b1,3'd3,16'hBEEF,3'd3,3'd0,16'h0000,16'h0000,16'h0000,16'h0000};
    vecs[1]  = '{1'b0,1'b0,1'b0,3'd0,16'h0000,3'd3,3'd5,16'h0000,16'h0000,16'h0000,16'h0000};
    vecs[2]  = '{1'b1,1'b0,1'b1,3'd3,16'hBEEF,3'd3,3'd3,16'hBEEF,16'hBEEF,16'h0000,16'h0000};
    vecs[3]  = '{1'b1,1'b0,1'b0,3'd3,16'h0000,3'd3,3'd0,16'hBEEF,16'h0000,16'hBEEF,16'h0000};
    vecs[4]  = '{1'b1,1'b0,1'b1,3'd1,16'h1111,3'd1,3'd6,16'h1111,16'h0000,16'h0000,16'h0000};
    vecs[5]  = '{1'b1,1'b0,1'b1,3'd6,16'h2222,3'd1,3'd6,16'h1111,16'h2222,16'h1111,16'h0000};
    vecs[6]  = '{1'b1,1'b0,1'b0,3'd0,16'h0000,3'd1,3'd6,16'h1111,16'h2222,16'h1111,16'h2222};
    vecs[7]  = '{1'b1,1'b0,1'b0,3'd0,16'h0000,3'd6,3'd1,16'h2222,16'h1111,16'h2222,16'h1111};
    vecs[8]  = '{1'b1,1'b0,1'b1,3'd0,16'h0000,3'd0,3'd3,16'h0000,16'hBEEF,16'h0000,16'hBEEF};
    vecs[9]  = '{1'b1,1'b0,1'b1,3'd1,16'h0001,3'd1,3'd6,16'h0001,16'h2222,16'h1111,16'h2222};
    vecs[10] = '{1'b1,1'b0,1'b1,3'd2,16'h0002,3'd2,3'd1,16'h0002,16'h0001,16'h0000,16'h0001};
    vecs[11] = '{1'b1,1'b0,1'b1,3'd3,16'h0003,3'd3,3'd2,16'h0003,16'h0002,16'hBEEF,16'h0002};
    vecs[12] = '{1'b1,1'b0,1'b1,3'd4,16'h0004,3'd4,3'd3,16'h0004,16'h0003,16'h0000,16'h0003};
    vecs[13] = '{1'b1,1'b0,1'b1,3'd5,16'h0005,3'd5,3'd4,16'h0005,16'h0004,16'h0000,16'h0004};
    vecs[14] = '{1'b1,1'b0,1'b1,3'd6,16'h0006,3'd6,3'd5,16'h0006,16'h0005,16'h2222,16'h0005};
    vecs[15] = '{1'b1,1'b0,1'b1,3'd7,16'h0007,3'd7,3'd6,16'h0007,16'h0006,16'h0000,16'h0006};
    vecs[16] = '{1'b1,1'b1,1'b1,3'd2,16'hABCD,3'd2,3'd7,16'h0002,16'h0007,16'h0002,16'h0007};
    vecs[17] = '{1'b1,1'b0,1'b0,3'd0,16'h0000,3'd2,3'd7,16'h0000,16'h0000,16'h0000,16'h0000};
    vecs[18] = '{1'b1,1'b0,1'b0,3'd0,16'h0000,3'd3,3'd6,16'h0000,16'h0000,16'h0000,16'h0000};
    vecs[19] = '{1'b1,1'b0,1'b1,3'd5,16'h5555,3'd5,3'd4,16'h5555,16'h0000,16'h0000,16'h0000};
    vecs[20] = '{1'b1,1'b0,1'b0,3'd0,16'h0000,3'd5,3'd5,16'h5555,16'h5555,16'h5555,16'h5555};
    vecs[21] = '{1'b0,1'b0,1'b1,3'd5,16'h9999,3'd5,3'd5,16'h0000,16'h0000,16'h0000,16'h0000};
    vecs[22] = '{1'b1,1'b0,1'b0,3'd0,16'h0000,3'd5,3'd5,16'h0000,16'h0000,16'h0000,16'h0000};
    vecs[23] = '{1'b1,1'b0,1'b1,3'd7,16'h7E7E,3'd7,3'd0,16'h7E7E,16'h0000,16'h0000,16'h0000};
    vecs[24] = '{1'b1,1'b0,1'b0,3'd0,16'h0000,3'd7,3'd7,16'h7E7E,16'h7E7E,16'h7E7E,16'h7E7E};

    // Table: reset/write, dual read, clear priority, async reset mid-cycle.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].clear, vecs[i].load, vecs[i].wa, vecs[i].din, 32'h0,
            vecs[i].ra, vecs[i].rb);
      push(0, {16'h0, vecs[i].e0a}, {16'h0, vecs[i].e0b}, $sformatf("v%0d bypass", i));
      push(1, {16'h0, vecs[i].e1a}, {16'h0, vecs[i].e1b}, $sformatf("v%0d nobypass", i));
      check_all();
    end

    // DEPTH=6, ZERO_REG=1: out-of-range writes/reads and hardwired register 0.
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd7, 3'd0);
    push(2, 32'h0, 32'h0, "d6 reset"); check_all();
    drive(1'b1, 1'b0, 1'b1, 3'd7, 16'h7777, 32'h0, 3'd7, 3'd5);
    push(2, 32'h0, 32'h0, "d6 wr7 bypass"); check_all();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'(i), 3'(7 - i));
      push(2, 32'h0, 32'h0, $sformatf("d6 after wr7 r%0d", i)); check_all();
    end
    drive(1'b1, 1'b0, 1'b1, 3'd0, 16'hFFFF, 32'h0, 3'd0, 3'd0);
    push(2, 32'h0, 32'h0, "d6 wr0 bypass"); check_all();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd0, 3'd0);
    push(2, 32'h0, 32'h0, "d6 after wr0"); check_all();
    drive(1'b1, 1'b0, 1'b1, 3'd5, 16'h5A5A, 32'h0, 3'd5, 3'd0);
    push(2, 32'h5A5A, 32'h0, "d6 wr5 bypass"); check_all();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd5, 3'd6);
    push(2, 32'h5A5A, 32'h0, "d6 after wr5"); check_all();

    // WIDTH=32 walking one, load toggling: only even steps write.
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd0, 3'd7);
    push(3, 32'h0, 32'h0, "w32 reset"); check_all();
    for (int i = 0; i < 8; i++) begin
      logic        ld;
      logic [31:0] pat;
      ld  = (i % 2 == 0);
      pat = 32'h8 << (4 * i);
      model32[i] = ld ? pat : 32'h0;
      drive(1'b1, 1'b0, ld, 3'(i), 16'h0, pat, 3'(i), 3'(i));
      push(3, model32[i], model32[i], $sformatf("w32 step%0d", i)); check_all();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 32'hFFFF_FFFF, 3'(i), 3'(7 - i));
      push(3, model32[i], model32[7 - i], $sformatf("w32 readback%0d", i)); check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Parametrised multi-register successor to the single 16-bit load register: DEPTH words of WIDTH bits.
- One synchronous write port and two independent combinational read ports.
- Adds asynchronous active-low reset, a synchronous clear-all, an optional hardwired-zero register 0, and optional write-to-read bypass.
- Sits between the ALU and the data path as the CPU's general-purpose register bank.

Parameters:
- WIDTH, 16, bits per register.
- DEPTH, 8, number of registers; must be >= 2; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- BYPASS, 1, when 1 a read of the address being written this cycle returns the write data (in); when 0 it returns the stored value.
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of all registers.
- load  input  1  write enable.
- waddr  input  ADDR_W  write address.
- in  input  WIDTH  write data.
- raddr_a  input  ADDR_W  read address, port A.
- out_a  output  WIDTH  read data, port A; combinational.
- raddr_b  input  ADDR_W  read address, port B.
- out_b  output  WIDTH  read data, port B; combinational.

Behaviour:
- Reset:
  - rst_n low clears every register to 0 immediately, without waiting for clk.
  - While rst_n is low, out_a and out_b are 0 regardless of addresses, load or BYPASS.
  - Release is synchronous-safe: the first rising edge with rst_n high performs a normal update.
- Rising edge with rst_n high, in priority order:
  - clear=1: all registers become 0; load is ignored that cycle.
  - clear=0 and load=1 and waddr < DEPTH: register[waddr] takes in.
  - Otherwise: all registers hold.
- Write latency:
  - New data is visible from the stored array one cycle after the edge.
  - With BYPASS=1 it is visible combinationally in the same cycle, via bypass.
- Read:
  - out_x = register[raddr_x]; purely combinational, zero-cycle latency.
  - Both ports may address the same or different registers simultaneously with no conflict.
- Bypass (BYPASS=1):
  - out_x = in when all of the following hold: rst_n=1, clear=0, load=1, waddr == raddr_x, waddr < DEPTH.
  - With clear=1 the bypass is suppressed, and out_x shows the stored value until the edge, then 0.
- Out-of-range addresses (DEPTH not a power of two):
  - A write with waddr >= DEPTH is dropped; no register changes.
  - A read with raddr_x >= DEPTH returns 0.
- ZERO_REG=1:
  - Register 0 is never written and always reads 0, including via bypass.
  - Storage for index 0 may be omitted.
- Reset mid-operation: an asserted rst_n overrides a concurrent clear or load; that edge's write is lost.
- No arithmetic is performed; data passes through unmodified at full WIDTH.
- No X may propagate from unused storage.

Test Plan:
- Reset then write (WIDTH=16, DEPTH=8):
  - rst_n=0 for 2 cycles: out_a=out_b=0000.
  - Release, then load=1, waddr=3, in=BEEF, with raddr_a=3.
  - BYPASS=1: out_a=BEEF in the same cycle; after the edge, out_a stays BEEF with load=0.
  - BYPASS=0: out_a=0000 before the edge, BEEF after.
- Dual read:
  - Write 1111 to reg 1 and 2222 to reg 6.
  - raddr_a=1, raddr_b=6: out_a=1111, out_b=2222.
  - Swap the addresses: the outputs swap in the same cycle.
- Clear priority:
  - Registers 0..7 loaded with 0..7 (value = index).
  - clear=1, load=1, waddr=2, in=ABCD: after the edge every register reads 0000, and out_a does not show ABCD before the edge.
- Async reset mid-cycle:
  - Reg 5 holds 5555; drop rst_n=0 at half-period with load=1, waddr=5, in=9999.
  - out_a (raddr_a=5) goes to 0000 before the next edge.
  - After release, reg 5 reads 0000.
- DEPTH=6, ZERO_REG=1:
  - Write waddr=7, in=7777: no register changes; raddr_a=7 reads 0000.
  - Write waddr=0, in=FFFF: raddr_b=0 reads 0000, including the bypass cycle.
  - Write waddr=5, in=5A5A: raddr_a=5 reads 5A5A.
- WIDTH=32 sweep:
  - Walking-one pattern written to each register over 8 cycles with load toggling every cycle.
  - Only load=1 edges update the array; the readback matches the expected model.
